// File: rtl/hex_display_pkg.sv
// Shared types and constants for the HEX display controller.
// Slot entries, FSM states and the blank segment pattern.
package hex_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam int NUM_DIGITS = 6;

    typedef struct packed {
        logic       blank;
        logic [3:0] value;
    } slot_t;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        SWEEP
    } state_t;

    localparam slot_t SLOT_RST = '{blank: 1'b1, value: 4'h0};

endpackage

// File: rtl/hex_display_ctrl_if.sv
// Write port of the HEX display controller: one slot write per
// valid/ready handshake.
interface hex_display_ctrl_if;

    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_digit;
    logic [3:0] wr_value;
    logic       wr_blank;

    modport master (
        output wr_valid,
        output wr_digit,
        output wr_value,
        output wr_blank,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_digit,
        input  wr_value,
        input  wr_blank,
        output wr_ready
    );

endinterface

// File: rtl/hex_seg_lut.sv
// Combinational nibble + blank to active-low 7-segment decoder.
// Output bit order is g..a (bit 0 = segment a).
module hex_seg_lut
    import hex_display_pkg::*;
(
    input  logic       blank,
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (value)
                4'h0: seg = 7'b1000000;
                4'h1: seg = 7'b1111001;
                4'h2: seg = 7'b0100100;
                4'h3: seg = 7'b0110000;
                4'h4: seg = 7'b0011001;
                4'h5: seg = 7'b0010010;
                4'h6: seg = 7'b0000010;
                4'h7: seg = 7'b1111000;
                4'h8: seg = 7'b0000000;
                4'h9: seg = 7'b0011000;
                4'hA: seg = 7'b0001000;
                4'hB: seg = 7'b0000011;
                4'hC: seg = 7'b1000110;
                4'hD: seg = 7'b0100001;
                4'hE: seg = 7'b0000110;
                default: seg = 7'b0001110;
            endcase
        end
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Six-digit HEX sequencer sharing one decoder; writes decode at once,
// periodic sweeps refresh all digits. Optional blink: HEX_BLINK_EN.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int REFRESH_DIV = 50_000_000
`ifdef HEX_BLINK_EN
  , parameter int BLINK_DIV = 25_000_000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    hex_display_ctrl_if.slave  bus,
`ifdef HEX_BLINK_EN
    input  logic [5:0]         blink_mask,
`endif
    output logic               sweep_done,
    output logic [6:0]         HEX0,
    output logic [6:0]         HEX1,
    output logic [6:0]         HEX2,
    output logic [6:0]         HEX3,
    output logic [6:0]         HEX4,
    output logic [6:0]         HEX5
);

    localparam int RW = $clog2(REFRESH_DIV);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  idx_q;
    logic [2:0]  dig_q;
    logic        pend_q;
    logic        ready_q;
    logic        done_q;
    logic [RW-1:0] ref_cnt;
    slot_t       slots_q [NUM_DIGITS];
    logic [6:0]  hex_q   [NUM_DIGITS];

    logic        accept;
    logic        load;
    logic        last;
    logic        wrap;
    logic        toggle;
    logic [2:0]  sel;
    logic        sel_ok;
    slot_t       slot_sel;
    logic        blank_eff;
    logic [6:0]  seg;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM: next state; a write in IDLE beats a pending sweep
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.wr_valid) state_d = UPDATE;
                else if (pend_q)  state_d = SWEEP;
            end
            UPDATE: state_d = IDLE;
            SWEEP:  if (idx_q == 3'd5) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: per-state controls
    always_comb begin
        accept = 1'b0;
        load   = 1'b0;
        last   = 1'b0;
        unique case (state_q)
            IDLE:   accept = bus.wr_valid;
            UPDATE: load = sel_ok;
            SWEEP: begin
                load = sel_ok;
                last = (idx_q == 3'd5);
            end
            default: ;
        endcase
    end

    assign wrap     = (ref_cnt == RW'(REFRESH_DIV - 1));
    assign sel      = (state_q == SWEEP) ? idx_q : dig_q;
    assign sel_ok   = (sel < 3'd6);
    assign slot_sel = sel_ok ? slots_q[sel] : SLOT_RST;

`ifdef HEX_BLINK_EN
    localparam int BW = $clog2(BLINK_DIV);

    logic [BW-1:0] blink_cnt;
    logic          blink_phase;

    assign toggle = (blink_cnt == BW'(BLINK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else begin
            blink_cnt <= toggle ? '0 : blink_cnt + BW'(1);
            if (toggle) blink_phase <= ~blink_phase;
        end
    end

    assign blank_eff = slot_sel.blank
                     | (sel_ok & blink_mask[sel] & ~blink_phase);
`else
    assign toggle    = 1'b0;
    assign blank_eff = slot_sel.blank;
`endif

    hex_seg_lut u_lut (
        .blank (blank_eff),
        .value (slot_sel.value),
        .seg   (seg)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            dig_q   <= '0;
            pend_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            ref_cnt <= '0;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                slots_q[i] <= SLOT_RST;
                hex_q[i]   <= SEG_BLANK;
            end
        end else begin
            ready_q <= (state_d == IDLE);
            done_q  <= (state_q == SWEEP) && (idx_q == 3'd4);
            idx_q   <= (state_q == SWEEP) ? idx_q + 3'd1 : 3'd0;
            ref_cnt <= wrap ? '0 : ref_cnt + RW'(1);
            if (accept) begin
                dig_q <= bus.wr_digit;
                if (bus.wr_digit < 3'd6)
                    slots_q[bus.wr_digit] <= '{blank: bus.wr_blank,
                                               value: bus.wr_value};
            end
            if (load) hex_q[sel] <= seg;
            // a wrap landing while a sweep is already owed is dropped
            if (last)               pend_q <= 1'b0;
            else if (wrap | toggle) pend_q <= 1'b1;
        end
    end

    assign bus.wr_ready = ready_q;
    assign sweep_done   = done_q;
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl with a short refresh period.
// Covers reset, writes, sweep deferral, invalid slot and mid-sweep reset.
module tb_hex_display_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sweep_done;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [6:0] hx [6];
    int         checks = 0;
    int         failures = 0;
    int         sd_cnt = 0;
    int         sd_snap;
`ifdef HEX_BLINK_EN
    logic [5:0] blink_mask = 6'b0;
    int         n_on;
    int         n_off;
`endif

    hex_display_ctrl_if bus ();

    hex_display_ctrl #(
        .REFRESH_DIV (16)
`ifdef HEX_BLINK_EN
      , .BLINK_DIV (8)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
`ifdef HEX_BLINK_EN
        .blink_mask (blink_mask),
`endif
        .sweep_done (sweep_done),
        .HEX0       (HEX0),
        .HEX1       (HEX1),
        .HEX2       (HEX2),
        .HEX3       (HEX3),
        .HEX4       (HEX4),
        .HEX5       (HEX5)
    );

    always #5 clk = ~clk;

    assign hx[0] = HEX0;
    assign hx[1] = HEX1;
    assign hx[2] = HEX2;
    assign hx[3] = HEX3;
    assign hx[4] = HEX4;
    assign hx[5] = HEX5;

    always @(negedge clk) if (sweep_done === 1'b1) sd_cnt++;

    task automatic chk(input string tag,
                       input logic [6:0] obs,
                       input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%b exp=%b", tag, obs, exp);
        end
    endtask

    task automatic wr(input int d, input int v, input bit b);
        int n = 0;
        @(negedge clk);
        while (bus.wr_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("wr_wait", {6'b0, bus.wr_ready}, 7'd1);
        bus.wr_valid = 1'b1;
        bus.wr_digit = 3'(d);
        bus.wr_value = 4'(v);
        bus.wr_blank = b;
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
    endtask

    // last round leaves 6,7,8,blank,A,b in digits 0..5
    task automatic burst();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 6; i++)
                wr(i, r * 6 + i, (r == 1 && i == 3));
    endtask

    logic [6:0] exp_b [6];

    initial begin
        exp_b[0] = 7'b0000010;
        exp_b[1] = 7'b1111000;
        exp_b[2] = 7'b0000000;
        exp_b[3] = 7'b1111111;
        exp_b[4] = 7'b0001000;
        exp_b[5] = 7'b0000011;

        bus.wr_valid = 1'b0;
        bus.wr_digit = 3'd0;
        bus.wr_value = 4'd0;
        bus.wr_blank = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 6; i++)
            chk($sformatf("rst_hex%0d", i), hx[i], 7'h7f);
        chk("rst_ready", {6'b0, bus.wr_ready}, 7'd1);
        chk("rst_done", {6'b0, sweep_done}, 7'd0);
        reset = 1'b0;

        wr(2, 4'hA, 1'b0);
        @(negedge clk);
        chk("wr_busy", {6'b0, bus.wr_ready}, 7'd0);
        @(negedge clk);
        chk("wr_hex2", HEX2, 7'b0001000);
        chk("wr_hex0", HEX0, 7'h7f);
        chk("wr_hex5", HEX5, 7'h7f);
        chk("wr_back", {6'b0, bus.wr_ready}, 7'd1);

        wr(0, 0, 1'b0);
        sd_snap = sd_cnt;
        for (int i = 1; i < 6; i++) wr(i, i, 1'b0);
        for (int i = 0; i < 6; i++)
            wr(i, 6 + i, (i == 3));
        @(negedge clk);
        chk("bb_update", {6'b0, bus.wr_ready}, 7'd0);
        chk("bb_no_sweep", 7'(sd_cnt - sd_snap), 7'd0);
        @(negedge clk);
        chk("bb_idle", {6'b0, bus.wr_ready}, 7'd1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("sw_busy%0d", k),
                {6'b0, bus.wr_ready}, 7'd0);
            chk($sformatf("sw_done%0d", k),
                {6'b0, sweep_done}, (k == 5) ? 7'd1 : 7'd0);
        end
        @(negedge clk);
        chk("sw_end_ready", {6'b0, bus.wr_ready}, 7'd1);
        chk("sw_end_done", {6'b0, sweep_done}, 7'd0);
        chk("sw_once", 7'(sd_cnt - sd_snap), 7'd1);
        for (int i = 0; i < 6; i++)
            chk($sformatf("bb_hex%0d", i), hx[i], exp_b[i]);

        wr(7, 4'h3, 1'b0);
        @(negedge clk);
        chk("d7_busy", {6'b0, bus.wr_ready}, 7'd0);
        @(negedge clk);
        for (int i = 0; i < 6; i++)
            chk($sformatf("d7_hex%0d", i), hx[i], exp_b[i]);

        burst();
        repeat (6) @(negedge clk);
        chk("mid_sweep", {6'b0, bus.wr_ready}, 7'd0);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 6; i++)
            chk($sformatf("ar_hex%0d", i), hx[i], 7'h7f);
        chk("ar_ready", {6'b0, bus.wr_ready}, 7'd1);
        chk("ar_done", {6'b0, sweep_done}, 7'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rel_ready", {6'b0, bus.wr_ready}, 7'd1);
        wr(1, 5, 1'b0);
        repeat (2) @(negedge clk);
        chk("rel_hex1", HEX1, 7'b0010010);
        chk("rel_hex0", HEX0, 7'h7f);
        chk("rel_hex4", HEX4, 7'h7f);

`ifdef HEX_BLINK_EN
        blink_mask = 6'b000001;
        wr(0, 1, 1'b0);
        n_on = 0;
        n_off = 0;
        repeat (60) begin
            @(negedge clk);
            if (HEX0 === 7'b1111001) n_on++;
            if (HEX0 === 7'b1111111) n_off++;
        end
        chk("blink_on", {6'b0, n_on > 0}, 7'd1);
        chk("blink_off", {6'b0, n_off > 0}, 7'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
